// File: rtl/rev_pkg.sv
// Shared definitions for the reversible gate cascade.
//   - Gate opcodes (2-bit op field of a program entry).
//   - Bit offsets of the fields inside a program entry
//     {op[1:0], ctrl[WIDTH-1:0], t0[IDX_W-1:0], t1[IDX_W-1:0]}.
//   - rev_apply(): applies one gate to a word. It works on MAX_W-bit
//     vectors so that it can serve any cascade width up to MAX_W-1 lines;
//     callers zero-extend their word and control mask and pass the real
//     line count in 'width'.
package rev_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_MCT  = 2'b01;
    localparam logic [1:0] OP_FRED = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;   // decodes as NOP

    localparam int MAX_W     = 32;
    localparam int MAX_IDX_W = 5;

    localparam int ENTRY_T1_LSB = 0;

    function automatic int entry_t0_lsb(input int idx_w);
        return idx_w;
    endfunction

    function automatic int entry_ctrl_lsb(input int idx_w);
        return 2 * idx_w;
    endfunction

    function automatic int entry_op_lsb(input int width, input int idx_w);
        return 2 * idx_w + width;
    endfunction

    // One reversible gate. Target lines are removed from the control mask
    // before the controls are tested, so a control bit on a target line
    // never blocks the gate. Out-of-range targets and a Fredkin swapping a
    // line with itself leave the word untouched.
    function automatic logic [MAX_W-1:0] rev_apply(
        input logic [MAX_W-1:0]     x,
        input logic [1:0]           op,
        input logic [MAX_W-1:0]     ctrl,
        input logic [MAX_IDX_W-1:0] t0,
        input logic [MAX_IDX_W-1:0] t1,
        input int                   width
    );
        logic [MAX_W-1:0] c;
        logic [MAX_W-1:0] y;
        logic             b0;
        logic             b1;
        c  = ctrl;
        y  = x;
        b0 = 1'b0;
        b1 = 1'b0;
        case (op)
            OP_MCT: begin
                if (int'(t0) < width) begin
                    c[t0] = 1'b0;
                    if ((x & c) == c) begin
                        y[t0] = ~x[t0];
                    end
                end
            end
            OP_FRED: begin
                if ((int'(t0) < width) && (int'(t1) < width) && (t0 != t1)) begin
                    c[t0] = 1'b0;
                    c[t1] = 1'b0;
                    if ((x & c) == c) begin
                        b0    = x[t0];
                        b1    = x[t1];
                        y[t0] = b1;
                        y[t1] = b0;
                    end
                end
            end
            default: ;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/rev_gate_stage.sv
// One pipeline stage of the reversible cascade.
// Applies the gate described by 'entry' to the word arriving from the
// previous stage and registers the result together with its valid flag and
// direction tag. Everything holds while 'stall' is high; the data/tag
// registers only load when a valid word arrives, so the data output keeps
// its last value across bubbles.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   stall        global hold
//   prev_valid   word from previous stage is valid
//   prev_data    word from previous stage
//   prev_rev     direction tag of that word
//   entry        program entry selected for this word's direction
//   stage_valid  registered valid
//   stage_data   registered gated word
//   stage_rev    registered direction tag
module rev_gate_stage
    import rev_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int IDX_W   = 2,
    parameter int ENTRY_W = 2 + WIDTH + 2 * IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               prev_valid,
    input  logic [WIDTH-1:0]   prev_data,
    input  logic               prev_rev,
    input  logic [ENTRY_W-1:0] entry,
    output logic               stage_valid,
    output logic [WIDTH-1:0]   stage_data,
    output logic               stage_rev
);

    localparam int T0_LSB   = entry_t0_lsb(IDX_W);
    localparam int CTRL_LSB = entry_ctrl_lsb(IDX_W);
    localparam int OP_LSB   = entry_op_lsb(WIDTH, IDX_W);

    logic [1:0]       op;
    logic [WIDTH-1:0] ctrl;
    logic [IDX_W-1:0] t0;
    logic [IDX_W-1:0] t1;
    logic [MAX_W-1:0] gated_full;
    logic [WIDTH-1:0] gated;
    logic             unused_upper_bits;

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             rev_reg;

    assign op   = entry[OP_LSB +: 2];
    assign ctrl = entry[CTRL_LSB +: WIDTH];
    assign t0   = entry[T0_LSB +: IDX_W];
    assign t1   = entry[ENTRY_T1_LSB +: IDX_W];

    assign gated_full = rev_apply(MAX_W'(prev_data), op, MAX_W'(ctrl),
                                  MAX_IDX_W'(t0), MAX_IDX_W'(t1), WIDTH);
    assign gated      = gated_full[WIDTH-1:0];

    // Bits above WIDTH are always zero-extension; fold them away.
    assign unused_upper_bits = ^gated_full[MAX_W-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            rev_reg   <= 1'b0;
        end else if (!stall) begin
            valid_reg <= prev_valid;
            if (prev_valid) begin
                data_reg <= gated;
                rev_reg  <= prev_rev;
            end
        end
    end

    assign stage_valid = valid_reg;
    assign stage_data  = data_reg;
    assign stage_rev   = rev_reg;

endmodule

// File: rtl/rev_gate_cascade.sv
// Pipelined reversible-logic engine: a loadable program of STAGES gates
// (multi-controlled NOT or Fredkin) applied to a WIDTH-bit word, one gate
// per pipeline stage. Each word carries a direction tag; reverse words walk
// the program from the last entry to the first, which undoes a forward pass
// because every gate is self-inverse.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data, in_rev       input word and direction (1 = reverse)
//   out_valid/out_ready   output handshake (driven straight from last stage)
//   out_data              result word, holds when out_valid=0
//   cfg_we/addr/data      program table write port
//   cfg_err               one-cycle pulse when a write was rejected
//   pipe_empty            no valid word in any stage
module rev_gate_cascade
    import rev_pkg::*;
#(
    parameter  int WIDTH   = 3,
    parameter  int STAGES  = 4,
    localparam int IDX_W   = $clog2(WIDTH),
    localparam int ENTRY_W = 2 + WIDTH + 2 * IDX_W,
    localparam int ADDR_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_rev,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_data,
    output logic               cfg_err,
    output logic               pipe_empty
);

    logic               stall;
    logic               accept;
    logic               cfg_addr_ok;
    logic               cfg_ok;
    logic               cfg_err_reg;

    logic [ENTRY_W-1:0] table_reg [STAGES];
    logic [ENTRY_W-1:0] stage_entry [STAGES];

    // Index 0 is the input port; index s+1 is the output of stage s.
    logic [STAGES:0]    chain_valid;
    logic [STAGES:0]    chain_rev;
    logic [WIDTH-1:0]   chain_data [STAGES+1];
    logic               unused_last_rev;

    // Global stall: the whole pipe freezes while the sink refuses a result.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    assign chain_valid[0] = accept;
    assign chain_data[0]  = in_data;
    assign chain_rev[0]   = in_rev;

    assign out_valid       = chain_valid[STAGES];
    assign out_data        = chain_data[STAGES];
    assign pipe_empty      = ~|chain_valid[STAGES:1];
    assign unused_last_rev = chain_rev[STAGES];

    // A table write is only safe when nothing is in flight and no word is
    // entering, so that every word sees one consistent program.
    assign cfg_addr_ok = ({{(32-ADDR_W){1'b0}}, cfg_addr} < 32'(STAGES));
    assign cfg_ok      = cfg_we & pipe_empty & ~accept & cfg_addr_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                table_reg[i] <= '0;          // all-zero entry is a NOP
            end
            cfg_err_reg <= 1'b0;
        end else begin
            if (cfg_ok) begin
                table_reg[cfg_addr] <= cfg_data;
            end
            cfg_err_reg <= cfg_we & ~cfg_ok;
        end
    end

    assign cfg_err = cfg_err_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            // Reverse words use the mirrored entry at this stage.
            assign stage_entry[gi] = chain_rev[gi] ? table_reg[STAGES-1-gi]
                                                   : table_reg[gi];

            rev_gate_stage #(
                .WIDTH   (WIDTH),
                .IDX_W   (IDX_W),
                .ENTRY_W (ENTRY_W)
            ) u_stage (
                .clk         (clk),
                .rst_n       (rst_n),
                .stall       (stall),
                .prev_valid  (chain_valid[gi]),
                .prev_data   (chain_data[gi]),
                .prev_rev    (chain_rev[gi]),
                .entry       (stage_entry[gi]),
                .stage_valid (chain_valid[gi+1]),
                .stage_data  (chain_data[gi+1]),
                .stage_rev   (chain_rev[gi+1])
            );
        end
    endgenerate

endmodule

// File: tb/tb_rev_gate_cascade.sv
// Self-checking bench for rev_gate_cascade (WIDTH=3, STAGES=4).
// Reference model: a copy of the program as plain integer fields plus a
// per-gate arithmetic rule; expected results are queued at accept time and
// compared whenever the sink takes a word.
module tb_rev_gate_cascade;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       in_rev;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [8:0] cfg_data;
    logic       cfg_err;
    logic       pipe_empty;

    rev_gate_cascade #(.WIDTH(3), .STAGES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_rev     (in_rev),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_err    (cfg_err),
        .pipe_empty (pipe_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int m_op[4];
    int m_ctrl[4];
    int m_t0[4];
    int m_t1[4];

    int exp_q[$];
    int got_q[$];
    int got_cyc[$];

    typedef struct {
        bit wr;
        int addr;
        int op;
        int ctrl;
        int t0;
        int t1;
        int din;
        bit rev;
        int exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int gate_model(input int x, input int e);
        int op   = m_op[e];
        int ctrl = m_ctrl[e];
        int t0   = m_t0[e];
        int t1   = m_t1[e];
        int mask;
        int y    = x;
        if (op == 1 && t0 < 3) begin
            mask = ctrl & ~(1 << t0);
            if ((x & mask) == mask) y = x ^ (1 << t0);
        end else if (op == 2 && t0 < 3 && t1 < 3 && t0 != t1) begin
            mask = ctrl & ~(1 << t0) & ~(1 << t1);
            if ((x & mask) == mask && ((x >> t0) & 1) != ((x >> t1) & 1))
                y = x ^ ((1 << t0) | (1 << t1));
        end
        return y;
    endfunction

    function automatic int cascade_model(input int x, input bit rev);
        int y = x;
        for (int s = 0; s < 4; s++) y = gate_model(y, rev ? 3 - s : s);
        return y;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_op[i] = 0; m_ctrl[i] = 0; m_t0[i] = 0; m_t1[i] = 0;
        end
    endfunction

    // One clock: settle, account for both handshakes, then advance.
    task automatic cycle();
        int e;
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("[%0d] out data=%03b exp=%03b", cyc, out_data, e[2:0]);
                check("out_data", int'(out_data), e);
            end
            got_q.push_back(int'(out_data));
            got_cyc.push_back(cyc);
        end
        if (rst_n && in_valid && in_ready)
            exp_q.push_back(cascade_model(int'(in_data), in_rev));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int i;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !out_valid && pipe_empty) break;
            cycle();
        end
        check("drain_timeout", (i >= 50) ? 1 : 0, 0);
    endtask

    task automatic send_one(input int x, input bit rev);
        in_valid = 1'b1;
        in_data  = x[2:0];
        in_rev   = rev;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic write_cfg(input int addr, input int op, input int ctrl,
                             input int t0, input int t1, input bit expect_ok);
        int word;
        word     = (op << 7) | (ctrl << 4) | (t0 << 2) | t1;
        cfg_we   = 1'b1;
        cfg_addr = addr[1:0];
        cfg_data = word[8:0];
        cycle();
        cfg_we = 1'b0;
        check("cfg_err", int'(cfg_err), expect_ok ? 0 : 1);
        if (expect_ok) begin
            m_op[addr] = op; m_ctrl[addr] = ctrl; m_t0[addr] = t0; m_t1[addr] = t1;
        end
        cycle();
        check("cfg_err_pulse", int'(cfg_err), 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rt[8];
        int exp2[8];
        int idx;
        int stall_left;
        int frozen;
        bit started;
        bit acc;

        exp2 = '{0, 1, 2, 7, 4, 5, 6, 3};
        //            wr addr op ctrl t0 t1  din   rev exp
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 3'b110, 0, 3'b110};
        vecs[1]  = '{1, 0, 1, 3, 2, 0, 3'b011, 0, 3'b111};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 3'b111, 0, 3'b011};
        vecs[3]  = '{1, 1, 2, 1, 1, 2, 3'b101, 0, 3'b011};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 3'b100, 0, 3'b100};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 3'b101, 1, 3'b111};
        vecs[6]  = '{1, 2, 2, 0, 0, 3, 3'b001, 0, 3'b001};
        vecs[7]  = '{1, 2, 1, 1, 0, 0, 3'b000, 0, 3'b001};
        vecs[8]  = '{1, 3, 3, 0, 1, 0, 3'b010, 0, 3'b011};
        vecs[9]  = '{1, 3, 1, 0, 1, 0, 3'b010, 1, 3'b001};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 3'b001, 0, 3'b010};

        in_valid = 0; in_data = 0; in_rev = 0; out_ready = 1;
        cfg_we = 0; cfg_addr = 0; cfg_data = 0; rst_n = 0;

        // Reset state
        do_reset();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_pipe_empty", int'(pipe_empty), 1);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // Identity table and latency
        send_one(3'b110, 0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        check("latency", lat, 4);
        drain();
        check("identity", (got_q.size() == 1) ? got_q[0] : -1, 3'b110);

        // Single Toffoli, back-to-back stream
        write_cfg(0, 1, 3'b011, 2, 0, 1);
        got_q.delete(); got_cyc.delete();
        for (int x = 0; x < 8; x++) begin
            in_valid = 1'b1; in_data = x[2:0]; in_rev = 1'b0;
            cycle();
        end
        drain();
        check("stream_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            check("toffoli_stream", got_q[i], exp2[i]);
            check("one_per_cycle", got_cyc[i] - got_cyc[0], i);
        end

        // Table-driven vectors, program accumulating
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr)
                write_cfg(vecs[i].addr, vecs[i].op, vecs[i].ctrl, vecs[i].t0, vecs[i].t1, 1);
            got_q.delete();
            send_one(vecs[i].din, vecs[i].rev);
            drain();
            check($sformatf("vec%0d", i), (got_q.size() == 1) ? got_q[0] : -1, vecs[i].exp);
        end

        // Round trip with the mixed program: forward pass, then reverse
        // results interleaved with repeated forward words.
        got_q.delete();
        for (int x = 0; x < 8; x++) begin
            in_valid = 1'b1; in_data = x[2:0]; in_rev = 1'b0;
            cycle();
        end
        drain();
        for (int x = 0; x < 8; x++) rt[x] = (x < got_q.size()) ? got_q[x] : 0;
        got_q.delete();
        for (int x = 0; x < 8; x++) begin
            in_valid = 1'b1; in_data = rt[x][2:0]; in_rev = 1'b1;
            cycle();
            in_data = x[2:0]; in_rev = 1'b0;
            cycle();
        end
        drain();
        check("roundtrip_count", got_q.size(), 16);
        for (int x = 0; x < 8 && 2 * x + 1 < got_q.size(); x++) begin
            check("roundtrip", got_q[2*x], x);
            check("fwd_repeat", got_q[2*x+1], rt[x]);
        end

        // Full pipe with a 3-cycle sink stall
        got_q.delete();
        idx = 0; stall_left = 0; started = 0; frozen = 0;
        for (int c = 0; c < 60 && got_q.size() < 8; c++) begin
            in_valid = (idx < 8);
            in_data  = idx[2:0];
            in_rev   = idx[0];
            if (!started && out_valid) begin
                started    = 1;
                stall_left = 3;
            end
            out_ready = !(stall_left > 0);
            #1;
            if (stall_left > 0) begin
                check("stall_in_ready", int'(in_ready), 0);
                check("stall_out_valid", int'(out_valid), 1);
                if (stall_left < 3) check("stall_frozen", int'(out_data), frozen);
                frozen = int'(out_data);
            end
            acc = in_valid && in_ready;
            cycle();
            if (acc) idx++;
            if (stall_left > 0) stall_left--;
        end
        drain();
        check("stall_all_out", got_q.size(), 8);

        // Randomized traffic over random programs
        for (int p = 0; p < 3; p++) begin
            for (int e = 0; e < 4; e++)
                write_cfg(e, $urandom_range(0, 3), $urandom_range(0, 7),
                          $urandom_range(0, 3), $urandom_range(0, 3), 1);
            for (int c = 0; c < 300; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = 3'($urandom_range(0, 7));
                in_rev    = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
                cycle();
            end
            drain();
        end

        // Rejected writes: pipe busy, and same-cycle accept
        write_cfg(3, 3, 0, 0, 0, 1);
        send_one(3'b010, 0);
        write_cfg(0, 1, 0, 0, 0, 0);
        drain();
        in_valid = 1'b1; in_data = 3'b111; in_rev = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 9'b01_000_01_00;
        cycle();
        in_valid = 1'b0; cfg_we = 1'b0;
        check("cfg_err_same_cycle", int'(cfg_err), 1);
        drain();
        for (int x = 0; x < 8; x++) begin
            in_valid = 1'b1; in_data = x[2:0]; in_rev = x[1];
            cycle();
        end
        drain();

        // Reset mid-stream
        for (int x = 0; x < 5; x++) begin
            in_valid = 1'b1; in_data = x[2:0]; in_rev = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_pipe_empty", int'(pipe_empty), 1);
        check("midrst_out_data", int'(out_data), 0);
        got_q.delete();
        send_one(3'b101, 1);
        drain();
        check("midrst_identity", (got_q.size() == 1) ? got_q[0] : -1, 3'b101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
